// File: rtl/adc_pingpong_logger.sv
// adc_pingpong_logger: serialises SAMPLE_W-bit ADC samples MSB-first into a
// two-bank byte RAM. Each full bank is flagged for the reader, which releases
// it with an ack. Supports continuous and single-shot capture, bank
// back-pressure, a sticky overrun flag and a saturating dropped-sample count.
module adc_pingpong_logger #(
  parameter int SAMPLE_W = 16,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                res,
  input  logic                start_pulse,
  input  logic                stop,
  input  logic                cont_mode,
  input  logic                drdy,
  input  logic [SAMPLE_W-1:0] din,
  input  logic                rd_bank,
  input  logic [ADDR_W-1:0]   read_addr,
  input  logic                ack,
  input  logic                ack_bank,
  output logic [7:0]          dout,
  output logic                write_done,
  output logic                full_bank,
  output logic [1:0]          pending,
  output logic                busy,
  output logic                overrun,
  output logic [7:0]          drop_cnt
);

  localparam int BYTES  = SAMPLE_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_WR   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [1:0]            pending_q, pending_d;
  logic                  full_bank_q, full_bank_d;
  logic                  write_done_q, write_done_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [7:0]            dout_q, dout_d;

  logic [7:0]            mem [0:2*DEPTH-1];
  logic                  mem_we;
  logic [ADDR_W:0]       mem_waddr;
  logic [7:0]            mem_wdata;

  logic [1:0]            pend_after_ack;
  logic [ADDR_W-1:0]     wr_ptr_inc;
  logic                  bank_done;
  logic                  drop_inc;

  // Next-state logic: capture, serialisation, bank hand-off and drop accounting.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    wr_ptr_d       = wr_ptr_q;
    byte_idx_d     = byte_idx_q;
    sample_d       = sample_q;
    full_bank_d    = full_bank_q;
    write_done_d   = 1'b0;
    overrun_d      = overrun_q;
    drop_cnt_d     = drop_cnt_q;
    mem_we         = 1'b0;
    mem_waddr      = {wr_bank_q, wr_ptr_q};
    mem_wdata      = sample_q[8*byte_idx_q +: 8];
    wr_ptr_inc     = wr_ptr_q + 1'b1;
    bank_done      = 1'b0;
    drop_inc       = 1'b0;
    dout_d         = mem[{rd_bank, read_addr}];

    // The reader's release is visible to this cycle's back-pressure decision.
    pend_after_ack = pending_q;
    if (ack) pend_after_ack[ack_bank] = 1'b0;
    pending_d      = pend_after_ack;

    if (start_pulse) begin
      state_d     = S_WAIT;
      wr_bank_d   = 1'b0;
      wr_ptr_d    = '0;
      byte_idx_d  = '0;
      pending_d   = 2'b00;
      full_bank_d = 1'b0;
      overrun_d   = 1'b0;
      drop_cnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (drdy) begin
            if (pend_after_ack[wr_bank_q]) begin
              overrun_d = 1'b1;
              drop_inc  = 1'b1;
            end else begin
              sample_d   = din;
              byte_idx_d = BIDX_W'(BYTES - 1);
              state_d    = S_WR;
            end
          end else if (stop) begin
            state_d = S_IDLE;
          end
        end
        S_WR: begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_inc;
          byte_idx_d = byte_idx_q - 1'b1;
          if (drdy) drop_inc = 1'b1;
          if (byte_idx_q == '0) begin
            bank_done = (wr_ptr_inc == '0);
            if (bank_done) begin
              pending_d[wr_bank_q] = 1'b1;
              full_bank_d          = wr_bank_q;
              write_done_d         = 1'b1;
              wr_bank_d            = ~wr_bank_q;
            end
            state_d = ((bank_done && !cont_mode) || stop) ? S_IDLE : S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (drop_inc && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Control and status registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge res) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (res) begin
      state_q      <= S_IDLE;
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      byte_idx_q   <= '0;
      sample_q     <= '0;
      pending_q    <= 2'b00;
      full_bank_q  <= 1'b0;
      write_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      byte_idx_q   <= byte_idx_d;
      sample_q     <= sample_d;
      pending_q    <= pending_d;
      full_bank_q  <= full_bank_d;
      write_done_q <= write_done_d;
      overrun_q    <= overrun_d;
      drop_cnt_q   <= drop_cnt_d;
      dout_q       <= dout_d;
    end
  end

  // Byte RAM write port; both banks share one array addressed by {bank, ptr}.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately left without reset so it maps onto a plain memory macro.
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dout       = dout_q;
  assign write_done = write_done_q;
  assign full_bank  = full_bank_q;
  assign pending    = pending_q;
  assign busy       = (state_q != S_IDLE);
  assign overrun    = overrun_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_adc_pingpong_logger.sv
// Self-checking bench for adc_pingpong_logger. Two instances: 16-bit samples
// with 256-byte banks and 32-bit samples with 32-byte banks; sel picks which
// one receives the control strobes and is compared. Expected values come from a
// transaction-level model: bank/address follow from the count of accepted
// bytes, and acceptance follows from the WAIT/back-pressure rules.
module tb_adc_pingpong_logger;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        res, start_pulse, stop, cont_mode, drdy, rd_bank, ack, ack_bank, sel;
  logic [31:0] din;
  logic [7:0]  read_addr;

  logic [7:0]  dout16, dout32, drop16, drop32;
  logic        wd16, wd32, fb16, fb32, busy16, busy32, ov16, ov32;
  logic [1:0]  pend16, pend32;

  adc_pingpong_logger #(.SAMPLE_W(16), .DEPTH(256), .ADDR_W(8)) u_dut16 (
    .clk(clk), .res(res), .start_pulse(start_pulse & ~sel), .stop(stop),
    .cont_mode(cont_mode), .drdy(drdy & ~sel), .din(din[15:0]),
    .rd_bank(rd_bank), .read_addr(read_addr), .ack(ack & ~sel), .ack_bank(ack_bank),
    .dout(dout16), .write_done(wd16), .full_bank(fb16), .pending(pend16),
    .busy(busy16), .overrun(ov16), .drop_cnt(drop16)
  );

  adc_pingpong_logger #(.SAMPLE_W(32), .DEPTH(32), .ADDR_W(5)) u_dut32 (
    .clk(clk), .res(res), .start_pulse(start_pulse & sel), .stop(stop),
    .cont_mode(cont_mode), .drdy(drdy & sel), .din(din),
    .rd_bank(rd_bank), .read_addr(read_addr[4:0]), .ack(ack & sel), .ack_bank(ack_bank),
    .dout(dout32), .write_done(wd32), .full_bank(fb32), .pending(pend32),
    .busy(busy32), .overrun(ov32), .drop_cnt(drop32)
  );

  logic [7:0] dout_m, drop_m;
  logic       wd_m, fb_m, busy_m, ov_m;
  logic [1:0] pend_m;
  assign dout_m = sel ? dout32 : dout16;
  assign drop_m = sel ? drop32 : drop16;
  assign wd_m   = sel ? wd32   : wd16;
  assign fb_m   = sel ? fb32   : fb16;
  assign busy_m = sel ? busy32 : busy16;
  assign ov_m   = sel ? ov32   : ov16;
  assign pend_m = sel ? pend32 : pend16;

  // Reference model state.
  int       m_bytes, m_depth, m_total, m_left, m_drop;
  bit       m_run, m_cmpl, m_cbank, m_ov, m_wd, m_fb;
  bit [1:0] m_pend;
  int       exp_mem [2][256];
  int       n_checks, n_pass, n_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic set_mode();
    m_bytes = sel ? 4 : 2;
    m_depth = sel ? 32 : 256;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++) exp_mem[b][a] = -1;
  endtask

  // Bytes of an aborted sample never reach the RAM.
  task automatic forget_unwritten();
    for (int k = m_total - m_left; k < m_total; k++)
      exp_mem[(k / m_depth) % 2][k % m_depth] = -1;
  endtask

  task automatic model_clear();
    forget_unwritten();
    m_total = 0; m_left = 0; m_pend = 2'b00; m_ov = 1'b0;
    m_drop = 0; m_wd = 1'b0; m_fb = 1'b0;
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // One clock of behaviour given this cycle's inputs.
  task automatic model_cycle(input bit d, input logic [31:0] v, input bit a, input bit ab);
    bit [1:0] pn;
    int       bank;
    m_wd = 1'b0;
    if (start_pulse) begin
      model_clear();
      m_run = 1'b1;
      return;
    end
    pn = m_pend;
    if (a) pn[ab] = 1'b0;
    if (m_run) begin
      if (m_left > 0) begin
        if (d) bump_drop();
        m_left--;
        if (m_left == 0) begin
          if (m_cmpl) begin
            pn[m_cbank] = 1'b1; m_wd = 1'b1; m_fb = m_cbank;
          end
          if ((m_cmpl && !cont_mode) || stop) m_run = 1'b0;
        end
      end else if (d) begin
        bank = (m_total / m_depth) % 2;
        if (pn[bank]) begin
          m_ov = 1'b1;
          bump_drop();
        end else begin
          for (int k = 0; k < m_bytes; k++)
            exp_mem[bank][(m_total + k) % m_depth] = (v >> (8 * (m_bytes - 1 - k))) & 32'hFF;
          m_total += m_bytes;
          m_cmpl  = (m_total % m_depth) == 0;
          m_cbank = bank[0];
          m_left  = m_bytes;
        end
      end else if (stop) begin
        m_run = 1'b0;
      end
    end
    m_pend = pn;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "write_done"}, wd_m,   m_wd);
    check({pfx, "full_bank"},  fb_m,   m_fb);
    check({pfx, "pending"},    pend_m, m_pend);
    check({pfx, "busy"},       busy_m, m_run);
    check({pfx, "overrun"},    ov_m,   m_ov);
    check({pfx, "drop_cnt"},   drop_m, m_drop);
  endtask

  task automatic step(input bit d, input logic [31:0] v, input bit a, input bit ab);
    drdy = d; din = v; ack = a; ack_bank = ab;
    model_cycle(d, v, a, ab);
    @(posedge clk); #1;
    drdy = 1'b0; ack = 1'b0; start_pulse = 1'b0;
    if (wd_m) n_wd++;
    check_outputs("");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic start_log(input bit c);
    cont_mode = c; start_pulse = 1'b1; n_wd = 0;
    step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    res = 1'b1;
    @(posedge clk); #1;
    model_clear(); m_run = 1'b0;
    check_outputs("rst_");
    check("rst_dout", dout_m, 8'h00);
    res = 1'b0;
  endtask

  // Read one byte back; only addresses with a known expected value are compared.
  task automatic read_chk(input bit b, input int a);
    rd_bank = b; read_addr = a[7:0];
    step(1'b0, 32'h0, 1'b0, 1'b0);
    if (exp_mem[b][a] >= 0) check("dout", dout_m, exp_mem[b][a]);
  endtask

  task automatic read_bank(input bit b);
    for (int a = 0; a < m_depth; a++) read_chk(b, a);
  endtask

  initial begin
    logic [31:0] r;
    bit          a, ab;
    res = 1'b1; start_pulse = 1'b0; stop = 1'b0; cont_mode = 1'b1; drdy = 1'b0;
    rd_bank = 1'b0; ack = 1'b0; ack_bank = 1'b0; din = '0; read_addr = '0; sel = 1'b0;
    n_checks = 0; n_pass = 0; n_wd = 0; m_run = 1'b0; m_left = 0; m_total = 0;
    set_mode();
    repeat (2) @(posedge clk);
    apply_reset();

    // Continuous 16-bit capture: bank0 gets 0x0000..0x007F.
    start_log(1'b1);
    for (int i = 0; i < 128; i++) begin
      step(1'b1, i, 1'b0, 1'b0);
      idle(3);
    end
    check("t1_wd_count", n_wd, 1);
    check("t1_pending", pend_m, 2'b01);
    check("t1_full_bank", fb_m, 1'b0);
    read_bank(1'b0);
    read_chk(1'b0, 255);
    check("t1_last_byte", dout_m, 8'h7F);

    // Second bank without ack, then back-pressure drop, ack and recovery.
    for (int i = 128; i < 256; i++) begin
      step(1'b1, i, 1'b0, 1'b0);
      idle(3);
    end
    check("t2_pending", pend_m, 2'b11);
    check("t2_full_bank", fb_m, 1'b1);
    step(1'b1, 32'h0000AAAA, 1'b0, 1'b0);
    check("t2_overrun", ov_m, 1'b1);
    check("t2_drop_cnt", drop_m, 8'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00001234, 1'b0, 1'b0);
    idle(3);
    read_bank(1'b1);
    read_chk(1'b0, 0);
    check("t2_bank0_addr0", dout_m, 8'h12);
    read_chk(1'b0, 1);

    // 32-bit samples every 2 cycles: one in three is accepted.
    sel = 1'b1;
    set_mode();
    apply_reset();
    start_log(1'b1);
    for (int i = 0; i < 24; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      idle(1);
    end
    idle(4);
    check("t3_drop_cnt", drop_m, 8'd16);
    check("t3_overrun", ov_m, 1'b0);
    check("t3_pending", pend_m, 2'b01);
    read_bank(1'b0);

    // Single-shot: one bank, then idle and deaf to drdy.
    start_log(1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      idle(4);
    end
    check("t4_busy", busy_m, 1'b0);
    check("t4_wd_count", n_wd, 1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      idle(4);
    end
    check("t4_drop_cnt", drop_m, 8'd0);
    read_bank(1'b0);

    // Stop raised while byte 1 of 4 is written.
    start_log(1'b1);
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    idle(2);
    stop = 1'b1;
    idle(3);
    stop = 1'b0;
    check("t5_busy", busy_m, 1'b0);
    check("t5_wd_count", n_wd, 0);
    check("t5_pending", pend_m, 2'b00);
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    idle(5);
    read_chk(1'b0, 0);
    check("t5_byte3", dout_m, 8'hCA);
    read_chk(1'b0, 3);
    check("t5_byte0", dout_m, 8'h0D);
    read_chk(1'b0, 4);

    // Randomised traffic with random releases of pending banks.
    start_log(1'b1);
    for (int i = 0; i < 1500; i++) begin
      a = 1'b0; ab = 1'b0;
      if (m_pend != 2'b00 && $urandom_range(0, 15) == 0) begin
        a  = 1'b1;
        ab = (m_pend == 2'b11) ? 1'($urandom_range(0, 1)) : m_pend[1];
      end
      r = $urandom;
      step($urandom_range(0, 2) == 0, r, a, ab);
    end
    stop = 1'b1;
    for (int i = 0; i < 10 && m_run; i++) idle(1);
    stop = 1'b0;
    check("rand_stopped", busy_m, 1'b0);
    read_bank(1'b0);
    read_bank(1'b1);

    // Asynchronous reset in the middle of a sample, then a clean restart.
    start_log(1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1);
    #3 res = 1'b1;
    #1;
    model_clear(); m_run = 1'b0;
    check_outputs("async_rst_");
    check("async_rst_dout", dout_m, 8'h00);
    @(posedge clk); #1;
    res = 1'b0;
    start_log(1'b1);
    step(1'b1, 32'h11223344, 1'b0, 1'b0);
    idle(5);
    read_chk(1'b0, 0);
    check("t6_addr0", dout_m, 8'h11);
    read_chk(1'b0, 3);
    check("t6_addr3", dout_m, 8'h44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
